hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/fwd_sel.sv | 32 +++
 rtl/hazard_fwd_unit.sv | 106 ++++++++++
 tb/tb_hazard_fwd_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared encodings and stage-record types for the 5-stage RISC-V pipeline.
//   FWD_*       : select encodings for the Execute operand forwarding muxes
//   RES_*       : result_src encodings carried down the pipeline
//   e_stage_t   : Execute shadow record tracked by the hazard unit
//   wb_stage_t  : Memory/Writeback shadow record (destination + write enable)
//   reg_hit()   : true when a producing stage writes a nonzero register that
//                 matches a consumer's source register
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from Writeback result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from Memory ALU result

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              is_load;
    } e_stage_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } wb_stage_t;

    // x0 is hard-wired to zero, so a "write" to it never produces a value.
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                     input logic              we,
                                     input logic [REG_AW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Forwarding select for one Execute source operand. Compares the operand's
// source register against the Memory and Writeback destinations; the younger
// Memory result wins when both match.
// Ports:
//   rs_e                 : Execute-stage source register
//   rd_m, reg_write_m    : Memory-stage destination and write enable
//   rd_w, reg_write_w    : Writeback-stage destination and write enable
//   fwd                  : FWD_RF / FWD_WB / FWD_MEM select (11 never driven)
// -----------------------------------------------------------------------------
module fwd_sel
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic [1:0]        fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_hit(rd_m, reg_write_m, rs_e)) begin
            fwd = FWD_MEM;
        end else if (reg_hit(rd_w, reg_write_w, rs_e)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Hazard detection and forwarding control for a 5-stage RISC-V pipeline.
// Keeps its own shadow copy of the E/M/W register fields it needs, so the
// only inputs are the Decode-stage fields and the Execute branch outcome.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   rs1_d, rs2_d, rd_d            : Decode-stage register specifiers
//   reg_write_d, result_src_d     : Decode-stage write enable / result source
//   pc_src_e                      : taken branch/jump resolved in Execute
//   forward_a_e, forward_b_e      : Execute operand forwarding selects
//   stall_f, stall_d              : hold Fetch / Decode pipeline registers
//   flush_d, flush_e              : bubble Decode / Execute pipeline registers
//   stall_cnt, flush_cnt          : saturating stall / flush event counters
// -----------------------------------------------------------------------------
module hazard_fwd_unit
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1_d,
    input  logic [4:0]        rs2_d,
    input  logic [4:0]        rd_d,
    input  logic              reg_write_d,
    input  logic [1:0]        result_src_d,
    input  logic              pc_src_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    e_stage_t  e_q;
    e_stage_t  e_next;
    wb_stage_t m_q;
    wb_stage_t w_q;
    logic      load_use;

    assign e_next = '{rs1:       rs1_d,
                      rs2:       rs2_d,
                      rd:        rd_d,
                      reg_write: reg_write_d,
                      is_load:   (result_src_d == RES_LOAD)};

    // Decode -> Execute: a load in E whose result a Decode reader needs
    // cannot be forwarded in time, so Decode waits one cycle.
    assign load_use = e_q.is_load && (e_q.rd != '0) &&
                      ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));

    // A taken branch squashes both younger instructions, so any load-use
    // stall on the wrong-path instruction in Decode is moot.
    assign stall_f = load_use && !pc_src_e;
    assign stall_d = load_use && !pc_src_e;
    assign flush_d = pc_src_e;
    assign flush_e = load_use || pc_src_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            e_q <= flush_e ? '0 : e_next;
            // Execute -> Memory -> Writeback: never stalled.
            m_q <= '{rd: e_q.rd, reg_write: e_q.reg_write};
            w_q <= m_q;
            if (stall_d) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (pc_src_e) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    fwd_sel u_fwd_a (
        .rs_e        (e_q.rs1),
        .rd_m        (m_q.rd),
        .reg_write_m (m_q.reg_write),
        .rd_w        (w_q.rd),
        .reg_write_w (w_q.reg_write),
        .fwd         (forward_a_e)
    );

    fwd_sel u_fwd_b (
        .rs_e        (e_q.rs2),
        .rd_m        (m_q.rd),
        .reg_write_m (m_q.reg_write),
        .rd_w        (w_q.rd),
        .reg_write_w (w_q.reg_write),
        .fwd         (forward_b_e)
    );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
// Directed instruction sequences driven into the Decode-stage inputs, with
// hand-computed forwarding, stall/flush and counter expectations.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic [4:0]       rd_d;
    logic             reg_write_d;
    logic [1:0]       result_src_d;
    logic             pc_src_e;
    logic [1:0]       forward_a_e;
    logic [1:0]       forward_b_e;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_chk;
    int n_err;

    hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_d         (rd_d),
        .reg_write_d  (reg_write_d),
        .result_src_d (result_src_d),
        .pc_src_e     (pc_src_e),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one Decode instruction (plus branch outcome) and let it settle.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw,
                         input logic [1:0] src, input logic pc);
        rs1_d        = rs1;
        rs2_d        = rs2;
        rd_d         = rd;
        reg_write_d  = rw;
        result_src_d = src;
        pc_src_e     = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
            tick();
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic sf, input logic sd,
                            input logic fd, input logic fe);
        chk({tag, ".stall_f"}, {31'd0, stall_f}, {31'd0, sf});
        chk({tag, ".stall_d"}, {31'd0, stall_d}, {31'd0, sd});
        chk({tag, ".flush_d"}, {31'd0, flush_d}, {31'd0, fd});
        chk({tag, ".flush_e"}, {31'd0, flush_e}, {31'd0, fe});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);

        // Reset state
        chk("rst.fwd_a", {30'd0, forward_a_e}, 32'd0);
        chk("rst.fwd_b", {30'd0, forward_b_e}, 32'd0);
        chk_ctrl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst.flush_cnt", {28'd0, flush_cnt}, 32'd0);
        // Branch seen during reset: flushes follow pc_src_e, counters stay 0
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1);
        chk_ctrl("rst_pc", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("rst_pc.flush_cnt", {28'd0, flush_cnt}, 32'd0);
        rst = 1'b0;
        nops(1);

        // add x5,x1,x2 ; add x6,x5,x1  -> M forwards to operand A
        drive(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0);
        chk_ctrl("alu_dep_d", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("b2b.fwd_a", {30'd0, forward_a_e}, 32'd2);
        chk("b2b.fwd_b", {30'd0, forward_b_e}, 32'd0);
        tick();
        nops(3);

        // add x5 ; nop ; sub x7,x1,x5  -> W forwards to operand B
        drive(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0);
        tick();
        nops(1);
        drive(5'd1, 5'd5, 5'd7, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("gap1.fwd_b", {30'd0, forward_b_e}, 32'd1);
        chk("gap1.fwd_a", {30'd0, forward_a_e}, 32'd0);
        tick();
        nops(3);

        // add x5 ; add x5 ; sub x7,x1,x5  -> M beats W
        drive(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd3, 5'd4, 5'd5, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd1, 5'd5, 5'd7, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("prio.fwd_b", {30'd0, forward_b_e}, 32'd2);
        tick();
        nops(3);

        // lw x8 ; add x9,x8,x2  -> one stall, then W forwards to operand A
        drive(5'd1, 5'd0, 5'd8, 1'b1, 2'b01, 1'b0);
        tick();
        drive(5'd8, 5'd2, 5'd9, 1'b1, 2'b00, 1'b0);
        chk_ctrl("lu", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(5'd8, 5'd2, 5'd9, 1'b1, 2'b00, 1'b0);
        chk_ctrl("lu_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu.stall_cnt", {28'd0, stall_cnt}, 32'd1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("lu.fwd_a", {30'd0, forward_a_e}, 32'd1);
        chk("lu.fwd_b", {30'd0, forward_b_e}, 32'd0);
        tick();
        nops(3);

        // x0: lw x0 ; add x0,x0,x0 ; add x3,x0,x0  -> no stall, no forward
        drive(5'd1, 5'd2, 5'd0, 1'b1, 2'b01, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0);
        chk_ctrl("x0_lu", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd3, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("x0.fwd_a", {30'd0, forward_a_e}, 32'd0);
        chk("x0.fwd_b", {30'd0, forward_b_e}, 32'd0);
        tick();
        nops(3);

        // load-use coinciding with taken branch: flush wins
        drive(5'd1, 5'd0, 5'd8, 1'b1, 2'b01, 1'b0);
        tick();
        drive(5'd2, 5'd8, 5'd9, 1'b1, 2'b00, 1'b1);
        chk_ctrl("lu_br", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("lu_br.flush_cnt", {28'd0, flush_cnt}, 32'd1);
        chk("lu_br.stall_cnt", {28'd0, stall_cnt}, 32'd1);
        tick();
        nops(3);

        // 20 stall cycles: self-dependent load repeated stalls every other cycle
        for (int i = 0; i < 40; i++) begin
            drive(5'd8, 5'd0, 5'd8, 1'b1, 2'b01, 1'b0);
            if (i == 1 || i == 38 || i == 39)
                chk($sformatf("sat.stall_d[%0d]", i), {31'd0, stall_d}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("sat.stall_cnt", {28'd0, stall_cnt}, 32'd15);
        tick();
        nops(2);

        // 20 taken branches: flush counter saturates too
        for (int i = 0; i < 20; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b1);
            tick();
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("sat.flush_cnt", {28'd0, flush_cnt}, 32'd15);
        chk("sat.stall_hold", {28'd0, stall_cnt}, 32'd15);
        tick();

        // Mid-stream reset with a forward in flight
        drive(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd5, 5'd5, 5'd6, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("pre_rst.fwd_a", {30'd0, forward_a_e}, 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst.fwd_a", {30'd0, forward_a_e}, 32'd0);
        chk("mid_rst.fwd_b", {30'd0, forward_b_e}, 32'd0);
        chk("mid_rst.stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("mid_rst.flush_cnt", {28'd0, flush_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        nops(1);

        // Normal tracking resumes after reset
        drive(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        chk("resume.fwd_a", {30'd0, forward_a_e}, 32'd2);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
